instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 99 +++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - single-outstanding-request instruction fetch unit with redirect
// An outstanding memory request is never withdrawn; a redirect while waiting parks in DROP until the ack.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ir,
  output logic        ir_valid,
  input  logic        ir_taken,
  output logic [31:0] pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FULL  = 2'd2,
    DROP  = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] fetch_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      pc       <= RESET_PC;
      ir       <= 32'h0;
      ir_valid <= 1'b0;
      mem_req  <= 1'b0;
      mem_addr <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          if (redirect) begin
            fetch_pc <= redirect_pc;
          end else if (start) begin
            state    <= FETCH;
            mem_req  <= 1'b1;
            mem_addr <= fetch_pc;
          end
        end
        FETCH: begin
          // mem_req low here means the request for fetch_pc is not yet issued
          if (!mem_req) begin
            if (redirect) begin
              fetch_pc <= redirect_pc;
            end else begin
              mem_req  <= 1'b1;
              mem_addr <= fetch_pc;
            end
          end else if (redirect) begin
            fetch_pc <= redirect_pc;
            if (mem_ack) mem_req <= 1'b0;
            else         state   <= DROP;
          end else if (mem_ack) begin
            ir       <= mem_rdata;
            pc       <= fetch_pc;
            fetch_pc <= fetch_pc + 32'd1;
            ir_valid <= 1'b1;
            mem_req  <= 1'b0;
            state    <= FULL;
          end
        end
        FULL: begin
          if (redirect) begin
            ir_valid <= 1'b0;
            fetch_pc <= redirect_pc;
            mem_req  <= 1'b1;
            mem_addr <= redirect_pc;
            state    <= FETCH;
          end else if (ir_taken) begin
            ir_valid <= 1'b0;
            mem_req  <= 1'b1;
            mem_addr <= fetch_pc;
            state    <= FETCH;
          end
        end
        DROP: begin
          if (redirect) fetch_pc <= redirect_pc;
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
